// File: rtl/uart_receiver.sv
// UART receiver: 8N1 framing, mid-bit sampling from a single down-counter.
// Optional even-parity bit when UART_RX_PARITY_EN is defined (adds o_parity_err).
module uart_receiver #(
    parameter int BAUD_RATE = 115200,
    parameter int CLK_FREQ  = 25000000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_uart,
    output logic [7:0] o_byte,
    output logic       o_valid,
    output logic       o_frame_err,
`ifdef UART_RX_PARITY_EN
    output logic       o_parity_err,
`endif
    output logic       o_busy
);

    localparam int BAUD_PERIOD = CLK_FREQ / BAUD_RATE;
    localparam int HALF_PERIOD = BAUD_PERIOD / 2;
    localparam logic [15:0] BAUD_RELOAD = 16'(BAUD_PERIOD - 1);
    localparam logic [15:0] HALF_RELOAD = 16'(HALF_PERIOD - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_t;

    state_t      r_state, w_next;
    logic        r_sync1, r_sync2;
    logic [15:0] r_cnt;
    logic [2:0]  r_idx;
    logic [7:0]  r_shift;
    logic [7:0]  r_byte;
    logic        r_valid, r_ferr;
    logic        w_rx, w_zero;

    assign w_rx   = r_sync2;
    assign w_zero = (r_cnt == 16'd0);

    // Line is asynchronous; nothing past this pair looks at i_uart directly.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_uart;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:   if (!w_rx) w_next = START;
            START:  if (w_zero) w_next = w_rx ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
            DATA:   if (w_zero && r_idx == 3'd7) w_next = PARITY;
            PARITY: if (w_zero) w_next = STOP;
`else
            DATA:   if (w_zero && r_idx == 3'd7) w_next = STOP;
`endif
            STOP:   if (w_zero) w_next = w_rx ? IDLE : BREAK;
            BREAK:  if (w_rx) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

`ifdef UART_RX_PARITY_EN
    logic r_par, r_perr;
    logic w_par_ok;
    assign w_par_ok     = ~(^{r_shift, r_par});
    assign o_parity_err = r_perr;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt   <= 16'd0;
            r_idx   <= 3'd0;
            r_shift <= 8'h00;
            r_byte  <= 8'h00;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par   <= 1'b0;
            r_perr  <= 1'b0;
`endif
        end else begin
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_perr  <= 1'b0;
`endif
            case (r_state)
                IDLE: if (!w_rx) r_cnt <= HALF_RELOAD;
                START: begin
                    if (w_zero) begin
                        r_cnt <= BAUD_RELOAD;
                        r_idx <= 3'd0;
                    end else r_cnt <= r_cnt - 16'd1;
                end
                DATA: begin
                    if (w_zero) begin
                        r_shift[r_idx] <= w_rx;
                        r_cnt          <= BAUD_RELOAD;
                        r_idx          <= r_idx + 3'd1;
                    end else r_cnt <= r_cnt - 16'd1;
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (w_zero) begin
                        r_par <= w_rx;
                        r_cnt <= BAUD_RELOAD;
                    end else r_cnt <= r_cnt - 16'd1;
                end
`endif
                STOP: begin
                    if (w_zero) begin
                        // A low stop bit outranks any parity verdict.
                        if (w_rx) begin
`ifdef UART_RX_PARITY_EN
                            if (w_par_ok) begin
                                r_byte  <= r_shift;
                                r_valid <= 1'b1;
                            end else r_perr <= 1'b1;
`else
                            r_byte  <= r_shift;
                            r_valid <= 1'b1;
`endif
                        end else r_ferr <= 1'b1;
                    end else r_cnt <= r_cnt - 16'd1;
                end
                default: ;
            endcase
        end
    end

    assign o_byte      = r_byte;
    assign o_valid     = r_valid;
    assign o_frame_err = r_ferr;
    assign o_busy      = (r_state != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 217 clocks/bit; define UART_RX_PARITY_EN for parity build.
module tb_uart_receiver;

    localparam int BIT = 217;

    logic       gclk = 1'b0;
    logic       i_rst, i_uart;
    logic [7:0] o_byte;
    logic       o_valid, o_frame_err, o_busy;
`ifdef UART_RX_PARITY_EN
    logic       o_parity_err;
`endif

    int vectors = 0, miscompares = 0;
    int valid_cnt = 0, valid_hi = 0, ferr_cnt = 0, both_cnt = 0, perr_cnt = 0;
    logic [7:0] rx_q[$];

    always #5 gclk = ~gclk;

    uart_receiver #(.BAUD_RATE(115200), .CLK_FREQ(25000000)) dut (
        .i_clk       (gclk),
        .i_rst       (i_rst),
        .i_uart      (i_uart),
        .o_byte      (o_byte),
        .o_valid     (o_valid),
        .o_frame_err (o_frame_err),
`ifdef UART_RX_PARITY_EN
        .o_parity_err(o_parity_err),
`endif
        .o_busy      (o_busy)
    );

    // Pulse monitor: a pulse lasting more than one cycle shows up as valid_hi > valid_cnt.
    logic prev_valid = 1'b0;
    always @(negedge gclk) begin
        if (o_valid) begin
            valid_hi++;
            if (!prev_valid) begin
                valid_cnt++;
                rx_q.push_back(o_byte);
            end
        end
        prev_valid = o_valid;
        if (o_frame_err) ferr_cnt++;
        if (o_valid && o_frame_err) both_cnt++;
`ifdef UART_RX_PARITY_EN
        if (o_parity_err) perr_cnt++;
        if (o_parity_err && (o_valid || o_frame_err)) both_cnt++;
`endif
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge gclk);
    endtask

    task automatic send_bit(input logic b);
        i_uart = b;
        wait_clk(BIT);
    endtask

    // flip_par inverts the even-parity bit in parity builds; ignored otherwise.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic flip_par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^d) ^ flip_par);
`endif
        send_bit(stop);
    endtask

    int busy_len;
    int v0, f0;

    initial begin
        i_rst  = 1'b1;
        i_uart = 1'b1;
        wait_clk(3);
        i_uart = 1'b0;
        wait_clk(5);
        chk("rst_byte",  32'(o_byte), 32'h00);
        chk("rst_valid", 32'(o_valid), 32'h0);
        chk("rst_ferr",  32'(o_frame_err), 32'h0);
        chk("rst_busy",  32'(o_busy), 32'h0);
        i_uart = 1'b1;
        wait_clk(5);
        i_rst = 1'b0;
        wait_clk(20);
        chk("idle_busy", 32'(o_busy), 32'h0);

        // single byte
        send_frame(8'hA5, 1'b1, 1'b0);
        wait_clk(300);
        chk("a5_count", 32'(valid_cnt), 32'd1);
        chk("a5_byte",  32'(o_byte), 32'hA5);
        chk("a5_ferr",  32'(ferr_cnt), 32'd0);

        // back-to-back, no idle gap
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        wait_clk(300);
        chk("b2b_count", 32'(valid_cnt), 32'd3);
        chk("b2b_first", 32'(rx_q[1]), 32'h00);
        chk("b2b_second", 32'(rx_q[2]), 32'hFF);
        chk("b2b_byte", 32'(o_byte), 32'hFF);

        // 50-clock glitch: start sample sees high again, no pulse
        busy_len = 0;
        i_uart = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (i == 50) i_uart = 1'b1;
            if (o_busy) busy_len++;
            @(negedge gclk);
        end
        chk("glitch_busy_len", 32'(busy_len >= 108 && busy_len <= 109), 32'd1);
        chk("glitch_valid", 32'(valid_cnt), 32'd3);
        chk("glitch_ferr",  32'(ferr_cnt), 32'd0);
        chk("glitch_idle",  32'(o_busy), 32'h0);

        // framing error then break
        send_frame(8'h3C, 1'b0, 1'b0);
        wait_clk(5000);
        chk("brk_ferr",  32'(ferr_cnt), 32'd1);
        chk("brk_valid", 32'(valid_cnt), 32'd3);
        chk("brk_byte",  32'(o_byte), 32'hFF);
        chk("brk_busy",  32'(o_busy), 32'h1);
        i_uart = 1'b1;
        wait_clk(50);
        chk("brk_exit", 32'(o_busy), 32'h0);
        chk("brk_ferr_hold", 32'(ferr_cnt), 32'd1);
        send_frame(8'h5A, 1'b1, 1'b0);
        wait_clk(300);
        chk("post_brk_count", 32'(valid_cnt), 32'd4);
        chk("post_brk_byte",  32'(o_byte), 32'h5A);

        // reset in the middle of data bit 4 of 8'h96
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'(8'h96 >> i));
        i_uart = 1'(8'h96 >> 4);
        wait_clk(BIT / 2);
        i_rst = 1'b1;
        wait_clk(2);
        chk("midrst_byte", 32'(o_byte), 32'h00);
        chk("midrst_busy", 32'(o_busy), 32'h0);
        i_uart = 1'b1;
        wait_clk(5);
        i_rst = 1'b0;
        wait_clk(300);
        chk("midrst_count", 32'(valid_cnt), 32'd4);
        chk("midrst_ferr",  32'(ferr_cnt), 32'd1);
        send_frame(8'h96, 1'b1, 1'b0);
        wait_clk(300);
        chk("after_rst_count", 32'(valid_cnt), 32'd5);
        chk("after_rst_byte",  32'(o_byte), 32'h96);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0);
        wait_clk(300);
        chk("par_ok_count", 32'(valid_cnt), 32'd6);
        chk("par_ok_byte",  32'(o_byte), 32'h07);
        chk("par_ok_perr",  32'(perr_cnt), 32'd0);
        send_frame(8'h07, 1'b1, 1'b1);
        wait_clk(300);
        chk("par_bad_count", 32'(valid_cnt), 32'd6);
        chk("par_bad_perr",  32'(perr_cnt), 32'd1);
`endif

        chk("single_cycle_pulses", 32'(valid_hi), 32'(valid_cnt));
        chk("no_overlap", 32'(both_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
